// File: rtl/dma_bram_responder.sv
// rtl/dma_bram_responder.sv - DMA BRAM-port responder: pipelined reads and priority writes on one single-port RAM
//
// Serves the DMA_Controller memory port on the Wishbone clock domain.
// Reads are accepted with a combinational ack. Their data returns a fixed
// READ_LAT cycles later, in ack order. Writes have no back-pressure and take
// the single RAM port whenever they are presented.
//
// Parameters:
//   ADDR_WIDTH  word address width of mem_r_addr / mem_w_addr
//   DATA_WIDTH  data word width
//   DEPTH       implemented words; addresses >= DEPTH are out of range
//   READ_LAT    cycles from ack edge to mem_r_valid (>= 1)
//   MAX_OUT     maximum accepted-but-unreturned reads (>= 1)
//
// Ports:
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_i     asynchronous active-high reset
//   mem_r_ready  read request; mem_r_addr is valid
//   mem_r_addr   read word address
//   mem_r_ack    read request accepted this cycle (combinational)
//   mem_r_valid  one-cycle read data pulse per accepted read
//   mem_r_data   read data; holds its last value while mem_r_valid = 0
//   mem_w_valid  write strobe; always accepted
//   mem_w_addr   write word address
//   mem_w_data   write data
//   err_o        sticky out-of-range access flag, cleared only by reset
//   rd_cnt_o     (DMA_RSP_STATS_EN only) count of acked reads, wraps
//   wr_cnt_o     (DMA_RSP_STATS_EN only) count of write strobes, wraps
//
// Build option:
//   DMA_RSP_STATS_EN  adds the rd_cnt_o / wr_cnt_o statistics counters

module dma_bram_responder #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int READ_LAT   = 2,
    parameter int MAX_OUT    = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  mem_r_ready,
    input  logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_r_ack,
    output logic                  mem_r_valid,
    output logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_w_valid,
    input  logic [ADDR_WIDTH-1:0] mem_w_addr,
    input  logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  err_o
`ifdef DMA_RSP_STATS_EN
    ,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    localparam logic [CNT_W-1:0]    MAX_OUT_C = CNT_W'(MAX_OUT);
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  r_in_range;
    logic                  w_in_range;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [CNT_W-1:0]      out_cnt;

    // Stage READ_LAT-1 is the output register pair. A stage's data only
    // moves when a valid word moves into it, so the last stage keeps the
    // most recently returned word while nothing is being returned.
    logic [READ_LAT-1:0]                 pipe_vld;
    logic [READ_LAT-1:0][DATA_WIDTH-1:0] pipe_data;

    always_comb begin
        r_in_range = ({1'b0, mem_r_addr} < DEPTH_C);
        w_in_range = ({1'b0, mem_w_addr} < DEPTH_C);
        r_idx      = mem_r_addr[IDX_W-1:0];
        w_idx      = mem_w_addr[IDX_W-1:0];
    end

    // A write owns the single port for its cycle, so reads wait. The
    // outstanding limit uses the registered count, which means a return
    // frees a slot only from the following cycle on.
    assign mem_r_ack = ~wb_rst_i & mem_r_ready & ~mem_w_valid & (out_cnt < MAX_OUT_C);

    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[r_idx];
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_w_valid && w_in_range) begin
            mem[w_idx] <= mem_w_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pipe_vld  <= '0;
            pipe_data <= '0;
        end else begin
            // Data is captured at the ack edge, so a later write to the same
            // address cannot change a read that is already in flight.
            pipe_vld[0] <= mem_r_ack;
            if (mem_r_ack) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign mem_r_valid = pipe_vld[READ_LAT-1];
    assign mem_r_data  = pipe_data[READ_LAT-1];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_cnt <= '0;
        end else begin
            case ({mem_r_ack, mem_r_valid})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_o <= 1'b0;
        end else if ((mem_w_valid && !w_in_range) || (mem_r_ack && !r_in_range)) begin
            err_o <= 1'b1;
        end
    end

`ifdef DMA_RSP_STATS_EN
    // Dropped out-of-range writes are counted too; both counters wrap.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            if (mem_r_ack) begin
                rd_cnt_o <= rd_cnt_o + 16'd1;
            end
            if (mem_w_valid) begin
                wr_cnt_o <= wr_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dma_bram_responder.sv
// tb/tb_dma_bram_responder.sv - self-checking bench for dma_bram_responder

module tb_dma_bram_responder;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int RL    = 2;
    localparam int MO    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r_ready = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic          r_ack;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_valid = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          err;

    logic          b_ready = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic          b_ack;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_wv = 1'b0;
    logic [AW-1:0] b_waddr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_err;

`ifdef DMA_RSP_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dma_bram_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LAT(RL), .MAX_OUT(MO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .mem_r_ready(r_ready),
        .mem_r_addr (r_addr),
        .mem_r_ack  (r_ack),
        .mem_r_valid(r_valid),
        .mem_r_data (r_data),
        .mem_w_valid(w_valid),
        .mem_w_addr (w_addr),
        .mem_w_data (w_data),
        .err_o      (err)
`ifdef DMA_RSP_STATS_EN
        ,
        .rd_cnt_o   (rd_cnt),
        .wr_cnt_o   (wr_cnt)
`endif
    );

    dma_bram_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LAT(6), .MAX_OUT(4)
    ) dut_slow (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .mem_r_ready(b_ready),
        .mem_r_addr (b_addr),
        .mem_r_ack  (b_ack),
        .mem_r_valid(b_valid),
        .mem_r_data (b_data),
        .mem_w_valid(b_wv),
        .mem_w_addr (b_waddr),
        .mem_w_data (b_wdata),
        .err_o      (b_err)
`ifdef DMA_RSP_STATS_EN
        ,
        .rd_cnt_o   (b_rd_cnt),
        .wr_cnt_o   (b_wr_cnt)
`endif
    );

    // Reference model of the default instance: a word array for the RAM and
    // a queue of (return edge, data) entries for accepted reads.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend[$];
    logic [DW-1:0] m_mem [0:DEPTH-1];
    int            m_out   = 0;
    int            m_cyc   = 0;
    logic          m_err   = 1'b0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_out   = 0;
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_cyc   = 0;
        end else begin
            bit    acc;
            pend_t p;
            acc   = r_ready && !w_valid && (m_out < MO);
            m_out = m_out + int'(acc) - int'(m_valid);
            if (w_valid) begin
                if (int'(w_addr) < DEPTH) m_mem[int'(w_addr)] = w_data;
                else                      m_err = 1'b1;
            end
            if (acc) begin
                p.due  = m_cyc + RL - 1;
                p.data = (int'(r_addr) < DEPTH) ? m_mem[int'(r_addr)] : '0;
                if (int'(r_addr) >= DEPTH) m_err = 1'b1;
                pend.push_back(p);
            end
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_valid = 1'b1;
                m_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                m_valid = 1'b0;
            end
            m_cyc++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r_ready = 1'b0;
            w_valid = 1'b0;
            b_ready = 1'b0;
            b_wv    = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        r_ready = 1'b0;
        w_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (r_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack got=%b exp=0", r_ack); end
        n_tests++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", r_valid); end
        n_tests++; if (r_data !== '0)    begin n_fail++; $display("FAIL reset_data got=%h exp=0", r_data); end
        n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        r_ready = 1'b1;
        #1;
        n_tests++; if (r_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack_forced got=%b exp=0", r_ack); end
        @(negedge clk);
        r_ready = 1'b0;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_burst;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_addr  = AW'(13'h100 + i);
            w_data  = DW'(32'hA0 + i);
        end
        for (int j = 0; j < 8; j++) begin
            logic e_ack, e_val;
            @(negedge clk);
            w_valid = 1'b0;
            r_ready = (j < 4);
            r_addr  = AW'(13'h100 + j);
            #1;
            e_ack = (j < 4);
            e_val = (j >= 2) && (j < 6);
            n_tests++; if (r_ack !== e_ack)   begin n_fail++; $display("FAIL burst_ack c%0d got=%b exp=%b", j, r_ack, e_ack); end
            n_tests++; if (r_valid !== e_val) begin n_fail++; $display("FAIL burst_valid c%0d got=%b exp=%b", j, r_valid, e_val); end
            if (e_val) begin
                n_tests++;
                if (r_data !== DW'(32'hA0 + j - 2)) begin
                    n_fail++; $display("FAIL burst_data c%0d got=%h exp=%h", j, r_data, 32'hA0 + j - 2);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_write_priority;
        @(negedge clk);
        w_valid = 1'b1; w_addr = 13'h010; w_data = 32'h11;
        @(negedge clk);
        r_ready = 1'b1; r_addr = 13'h010;
        w_valid = 1'b1; w_addr = 13'h010; w_data = 32'h55;
        #1;
        n_tests++; if (r_ack !== 1'b0) begin n_fail++; $display("FAIL prio_ack_blocked got=%b exp=0", r_ack); end
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL prio_ack_next got=%b exp=1", r_ack); end
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        n_tests++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid_early got=%b exp=0", r_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (r_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid got=%b exp=1", r_valid); end
        n_tests++; if (r_data !== 32'h55) begin n_fail++; $display("FAIL prio_data got=%h exp=00000055", r_data); end
        idle(2);
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        w_valid = 1'b1; w_addr = 13'h0800; w_data = 32'h7777;
        @(negedge clk);
        w_valid = 1'b0;
        r_ready = 1'b1; r_addr = 13'h1FFF;
        #1;
        n_tests++; if (err !== 1'b0)   begin n_fail++; $display("FAIL oor_err_pre got=%b exp=0", err); end
        n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL oor_ack got=%b exp=1", r_ack); end
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err_set got=%b exp=1", err); end
        @(negedge clk);
        w_valid = 1'b1; w_addr = 13'h1800; w_data = 32'hDEAD;
        #1;
        n_tests++; if (r_valid !== 1'b1) begin n_fail++; $display("FAIL oor_valid got=%b exp=1", r_valid); end
        n_tests++; if (r_data !== '0)    begin n_fail++; $display("FAIL oor_data got=%h exp=0", r_data); end
        @(negedge clk);
        w_valid = 1'b0;
        r_ready = 1'b1; r_addr = 13'h0800;
        #1;
        n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL oor_ack2 got=%b exp=1", r_ack); end
        @(negedge clk);
        r_ready = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (r_valid !== 1'b1)     begin n_fail++; $display("FAIL oor_valid2 got=%b exp=1", r_valid); end
        n_tests++; if (r_data !== 32'h7777)  begin n_fail++; $display("FAIL oor_alias_data got=%h exp=00007777", r_data); end
        n_tests++; if (err !== 1'b1)         begin n_fail++; $display("FAIL oor_err_sticky got=%b exp=1", err); end
        idle(2);
    endtask

    task automatic test_reset_midflight;
        int seen;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            r_ready = 1'b1; r_addr = AW'(13'h100 + i);
            #1;
            n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack c%0d got=%b exp=1", i, r_ack); end
        end
        @(negedge clk);
        r_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (r_valid === 1'b1) seen++;
        end
        n_tests++; if (seen != 0)     begin n_fail++; $display("FAIL mid_stale_valid got=%0d exp=0", seen); end
        n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL mid_err_cleared got=%b exp=0", err); end
`ifdef DMA_RSP_STATS_EN
        n_tests++; if (rd_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rd_cnt got=%0d exp=0", rd_cnt); end
        n_tests++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_wr_cnt got=%0d exp=0", wr_cnt); end
`endif
        @(negedge clk);
        r_ready = 1'b1; r_addr = 13'h101;
        #1;
        n_tests++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_after got=%b exp=1", r_ack); end
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        n_tests++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_early got=%b exp=0", r_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (r_valid !== 1'b1)   begin n_fail++; $display("FAIL mid_valid got=%b exp=1", r_valid); end
        n_tests++; if (r_data !== 32'hA1)  begin n_fail++; $display("FAIL mid_data got=%h exp=000000a1", r_data); end
`ifdef DMA_RSP_STATS_EN
        n_tests++; if (rd_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_rd_cnt_one got=%0d exp=1", rd_cnt); end
`endif
        idle(2);
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            w_valid = 1'b1; w_addr = AW'(13'h40 + i); w_data = $urandom;
        end
        for (int c = 0; c < 400; c++) begin
            logic e_ack;
            @(negedge clk);
            w_valid = ($urandom_range(0, 9) < 3);
            w_addr  = ($urandom_range(0, 19) == 0) ? AW'(13'h1000 + $urandom_range(0, 4095))
                                                   : AW'(13'h40 + $urandom_range(0, 15));
            w_data  = $urandom;
            r_ready = ($urandom_range(0, 9) < 7);
            r_addr  = ($urandom_range(0, 29) == 0) ? AW'(13'h1000 + $urandom_range(0, 4095))
                                                   : AW'(13'h40 + $urandom_range(0, 15));
            #1;
            e_ack = r_ready && !w_valid && (m_out < MO);
            n_tests++; if (r_ack !== e_ack)     begin n_fail++; $display("FAIL rnd_ack c%0d got=%b exp=%b", c, r_ack, e_ack); end
            n_tests++; if (r_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, r_valid, m_valid); end
            n_tests++; if (r_data !== m_data)   begin n_fail++; $display("FAIL rnd_data c%0d got=%h exp=%h", c, r_data, m_data); end
            n_tests++; if (err !== m_err)       begin n_fail++; $display("FAIL rnd_err c%0d got=%b exp=%b", c, err, m_err); end
        end
        idle(4);
    endtask

    task automatic test_stall;
        bit [31:0] ack_hist;
        int        outst;
        @(negedge clk);
        b_wv = 1'b1; b_waddr = 13'h020; b_wdata = 32'h1234;
        @(negedge clk);
        b_wv = 1'b0;
        ack_hist = '0;
        outst = 0;
        for (int i = 0; i < 24; i++) begin
            logic e_ack, e_val;
            @(negedge clk);
            b_ready = 1'b1; b_addr = 13'h020;
            #1;
            e_ack = (outst < 4);
            e_val = (i >= 6) ? ack_hist[i-6] : 1'b0;
            n_tests++; if (b_ack !== e_ack)   begin n_fail++; $display("FAIL stall_ack c%0d got=%b exp=%b", i, b_ack, e_ack); end
            n_tests++; if (b_valid !== e_val) begin n_fail++; $display("FAIL stall_valid c%0d got=%b exp=%b", i, b_valid, e_val); end
            if (e_val) begin
                n_tests++;
                if (b_data !== 32'h1234) begin n_fail++; $display("FAIL stall_data c%0d got=%h exp=00001234", i, b_data); end
            end
            ack_hist[i] = e_ack;
            outst = outst + int'(e_ack) - int'(e_val);
        end
        idle(10);
    endtask

    initial begin
        test_reset;
        test_burst;
        test_write_priority;
        test_out_of_range;
        test_reset_midflight;
        test_random;
        test_stall;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
